dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/DMA).
- Uses round-robin arbitration with a valid/ready request handshake and a registered, one-cycle response pulse.
- Sits between the requesters and the data memory.
- Drives the memory's mem_read, mem_write, address and write_data inputs, and consumes its combinational read_data.

---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between port 0 (CPU load/store)
// and port 1 (debug/DMA) with round-robin arbitration.
//
// Flow: a request is accepted (valid & ready) in IDLE or RESP. The next cycle
// (ACCESS) drives the memory. The cycle after that (RESP) carries a one-cycle
// response pulse on the granted port. A new request may be accepted during RESP,
// so the arbiter sustains one access every two cycles.
//
// Ports:
//   clock, reset                     rising-edge clock, asynchronous active-high reset
//   pN_req_valid/ready/we/addr/wdata request handshake and fields, N = 0, 1
//   pN_resp_valid                    one-cycle response pulse for port N
//   resp_rdata, resp_err             response payload, qualified by a resp_valid pulse
//   mem_read/write/address/write_data  registered memory controls, active only in ACCESS
//   mem_read_data                    combinational read data from the memory
//   stat_p0_count, stat_p1_count     per-port grant counters
//   stat_err_count                   rejected-request counter
//
// Optional feature: define DMEM_ARB_STATS_EN to build the saturating 16-bit
// statistics counters. When it is undefined, the stat outputs are tied to 0.

module dmem_arbiter #(
  parameter int unsigned ADDR_BITS         = 12,
  parameter int unsigned P0_PRIORITY_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [15:0] stat_p0_count,
  output logic [15:0] stat_p1_count,
  output logic [15:0] stat_err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // last_grant = 1 means port 1 won the previous handshake, so port 0 has priority next
  logic last_grant;
  logic lat_we;
  logic lat_err;
  logic lat_port;

  logic        can_accept_c;
  logic        grant0_c;
  logic        grant1_c;
  logic        accept_c;
  logic        win_port1_c;
  logic        req_we_c;
  logic [31:0] req_addr_c;
  logic [31:0] req_wdata_c;
  logic        req_err_c;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = accept_c ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arbitration, ready outputs and selected request fields
  always_comb begin
    can_accept_c = (state == IDLE) || (state == RESP);
    grant0_c     = p0_req_valid && (!p1_req_valid || last_grant);
    grant1_c     = p1_req_valid && (!p0_req_valid || !last_grant);
    p0_req_ready = can_accept_c && grant0_c;
    p1_req_ready = can_accept_c && grant1_c;
    accept_c     = p0_req_ready || p1_req_ready;
    win_port1_c  = p1_req_ready;
    req_we_c     = win_port1_c ? p1_req_we    : p0_req_we;
    req_addr_c   = win_port1_c ? p1_req_addr  : p0_req_addr;
    req_wdata_c  = win_port1_c ? p1_req_wdata : p0_req_wdata;
    // Misaligned or outside the byte-address window
    req_err_c    = (req_addr_c[1:0] != 2'b00) || ((req_addr_c >> ADDR_BITS) != 32'd0);
  end

  // Request latch, memory drive and response capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant     <= (P0_PRIORITY_RESET != 0);
      lat_we         <= 1'b0;
      lat_err        <= 1'b0;
      lat_port       <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      p0_resp_valid  <= 1'b0;
      p1_resp_valid  <= 1'b0;
    end else begin
      // Memory controls and response pulses last exactly one cycle
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      p0_resp_valid  <= 1'b0;
      p1_resp_valid  <= 1'b0;
      if (accept_c) begin
        last_grant <= win_port1_c;
        lat_we     <= req_we_c;
        lat_err    <= req_err_c;
        lat_port   <= win_port1_c;
        // Rejected requests never touch the memory
        if (!req_err_c) begin
          mem_read       <= !req_we_c;
          mem_write      <= req_we_c;
          mem_address    <= req_addr_c;
          mem_write_data <= req_wdata_c;
        end
      end
      if (state == ACCESS) begin
        resp_rdata    <= (!lat_we && !lat_err) ? mem_read_data : 32'd0;
        resp_err      <= lat_err;
        p0_resp_valid <= !lat_port;
        p1_resp_valid <= lat_port;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  // Saturating grant and error counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_p0_count  <= '0;
      stat_p1_count  <= '0;
      stat_err_count <= '0;
    end else if (accept_c) begin
      if (!win_port1_c && (stat_p0_count != '1))
        stat_p0_count <= stat_p0_count + STAT_W'(1);
      if (win_port1_c && (stat_p1_count != '1))
        stat_p1_count <= stat_p1_count + STAT_W'(1);
      if (req_err_c && (stat_err_count != '1))
        stat_err_count <= stat_err_count + STAT_W'(1);
    end
  end
`else
  assign stat_p0_count  = 16'd0;
  assign stat_p1_count  = 16'd0;
  assign stat_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Each port has its own request queue,
// and a driver presents those requests to the DUT. At each accepted handshake,
// the driver pushes the expected response (port, data, error, arrival cycle)
// onto a scoreboard. A shadow memory supplies the expected read data.
// Responses are popped from the scoreboard and compared when they appear.
module tb_dmem_arbiter;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [15:0] stat_p0_count, stat_p1_count, stat_err_count;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic port; logic [31:0] rdata; logic err; int cyc; } exp_t;
  typedef struct { logic port; int cyc; } grant_t;

  req_t   req_q0[$];
  req_t   req_q1[$];
  exp_t   exp_q[$];
  grant_t grant_q[$];

  logic [31:0] tb_mem [0:MEM_WORDS-1];
  logic [31:0] sb_mem [0:MEM_WORDS-1];

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int wr_pulses   = 0;
  int rd_pulses   = 0;
  int resp_pulses = 0;
  int last_wr_cyc = -1;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .stat_p0_count(stat_p0_count), .stat_p1_count(stat_p1_count),
    .stat_err_count(stat_err_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int i);
    return 32'hC000_0000 | 32'(i << 2);
  endfunction

  // Data memory model: combinational read, write on the rising edge
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] = pat(i);
    forever begin
      @(posedge clock);
      if (mem_write) tb_mem[mem_address[11:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = tb_mem[mem_address[11:2]];

  task automatic predict(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    exp_t e;
    grant_t g;
    logic err;
    err     = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    e.port  = port;
    e.err   = err;
    e.cyc   = cyc + 2;
    e.rdata = (we || err) ? 32'd0 : sb_mem[addr[11:2]];
    if (we && !err) sb_mem[addr[11:2]] = wdata;
    exp_q.push_back(e);
    g.port = port;
    g.cyc  = cyc;
    grant_q.push_back(g);
  endtask

  // Driver and response monitor
  initial begin : driver
    logic acc0, acc1;
    req_t r;
    exp_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) sb_mem[i] = pat(i);
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = 32'd0; p0_req_wdata = 32'd0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = 32'd0; p1_req_wdata = 32'd0;
    forever begin
      @(negedge clock);
      if (mem_write) begin wr_pulses++; last_wr_cyc = cyc; end
      if (mem_read) rd_pulses++;
      if (p0_resp_valid || p1_resp_valid) begin
        resp_pulses++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected: cyc=%0d p0=%b p1=%b got none expected", cyc,
                   p0_resp_valid, p1_resp_valid);
        end else begin
          e = exp_q.pop_front();
          if ((p0_resp_valid && p1_resp_valid) || (p1_resp_valid !== e.port) ||
              (resp_rdata !== e.rdata) || (resp_err !== e.err) || (cyc != e.cyc)) begin
            miscompares++;
            $display("FAIL resp: got p0=%b p1=%b rdata=%h err=%b cyc=%0d, expected port=%0d rdata=%h err=%b cyc=%0d",
                     p0_resp_valid, p1_resp_valid, resp_rdata, resp_err, cyc,
                     e.port, e.rdata, e.err, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL resp_missing: no response by cyc=%0d, expected at cyc=%0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (reset) begin
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        exp_q.delete();
      end else begin
        if (acc0) begin p0_req_valid = 1'b0; acc0 = 1'b0; end
        if (acc1) begin p1_req_valid = 1'b0; acc1 = 1'b0; end
        if (!p0_req_valid && req_q0.size() != 0) begin
          r = req_q0.pop_front();
          p0_req_valid = 1'b1; p0_req_we = r.we; p0_req_addr = r.addr; p0_req_wdata = r.wdata;
        end
        if (!p1_req_valid && req_q1.size() != 0) begin
          r = req_q1.pop_front();
          p1_req_valid = 1'b1; p1_req_we = r.we; p1_req_addr = r.addr; p1_req_wdata = r.wdata;
        end
        #1;
        if (p0_req_valid || p1_req_valid) begin
          vectors++;
          if ((p0_req_ready && p1_req_ready) || (p0_req_ready && !p0_req_valid) ||
              (p1_req_ready && !p1_req_valid)) begin
            miscompares++;
            $display("FAIL ready_excl: cyc=%0d valid=%b%b ready=%b%b, expected at most one ready to a valid port",
                     cyc, p0_req_valid, p1_req_valid, p0_req_ready, p1_req_ready);
          end
        end
        if (p0_req_valid && p0_req_ready) begin
          acc0 = 1'b1;
          predict(1'b0, p0_req_we, p0_req_addr, p0_req_wdata);
        end
        if (p1_req_valid && p1_req_ready) begin
          acc1 = 1'b1;
          predict(1'b1, p1_req_we, p1_req_addr, p1_req_wdata);
        end
      end
    end
  end

  function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req_q0.size() != 0 || req_q1.size() != 0 || p0_req_valid || p1_req_valid ||
            exp_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles, expected idle", n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vectors++;
    if ({mem_read, mem_write, mem_address, mem_write_data} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h, expected all 0",
               mem_read, mem_write, mem_address, mem_write_data);
    end
    vectors++;
    if ({p0_resp_valid, p1_resp_valid, resp_err, resp_rdata} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_resp: v0=%b v1=%b err=%b rdata=%h, expected all 0",
               p0_resp_valid, p1_resp_valid, resp_err, resp_rdata);
    end
    vectors++;
    if ({stat_p0_count, stat_p1_count, stat_err_count} !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_stats: %0d %0d %0d, expected 0 0 0", stat_p0_count, stat_p1_count, stat_err_count);
    end
    #2 reset = 1'b0;
    @(negedge clock);
    #3;
    vectors++;
    if ({p0_req_ready, p1_req_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_ready: ready=%b%b, expected 00 with no valid", p0_req_ready, p1_req_ready);
    end
  endtask

  task automatic test_alternate();
    int g0;
    g0 = grant_q.size();
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      req_q0.push_back(mk(1'b0, 32'h100 + 32'(i * 8), 32'd0));
      req_q1.push_back(mk(1'b0, 32'h104 + 32'(i * 8), 32'd0));
    end
    drain(60);
    vectors++;
    if (grant_q.size() != g0 + 8) begin
      miscompares++;
      $display("FAIL alt_count: grants=%0d, expected 8", grant_q.size() - g0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (grant_q[g0 + i].port !== 1'(i % 2) ||
            (i > 0 && grant_q[g0 + i].cyc != grant_q[g0 + i - 1].cyc + 2)) begin
          miscompares++;
          $display("FAIL alt_grant[%0d]: port=%0d cyc=%0d, expected port=%0d two cycles after the previous grant",
                   i, grant_q[g0 + i].port, grant_q[g0 + i].cyc, i % 2);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int g0, w0;
    g0 = grant_q.size();
    w0 = wr_pulses;
    req_q0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
    req_q0.push_back(mk(1'b0, 32'h10, 32'd0));
    drain(40);
    vectors++;
    if (wr_pulses - w0 != 1) begin
      miscompares++;
      $display("FAIL wr_pulses: got %0d, expected 1", wr_pulses - w0);
    end
    vectors++;
    if (grant_q.size() != g0 + 2 || last_wr_cyc != grant_q[g0].cyc + 1) begin
      miscompares++;
      $display("FAIL wr_timing: mem_write at cyc=%0d, expected the cycle after the accept edge", last_wr_cyc);
    end
    vectors++;
    if (tb_mem[4] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_commit: mem[0x10]=%h, expected deadbeef", tb_mem[4]);
    end
  endtask

  task automatic test_error();
    int w0, r0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    req_q1.push_back(mk(1'b0, 32'h0000_1000, 32'd0));
    req_q1.push_back(mk(1'b1, 32'h6, 32'h1234_5678));
    drain(40);
    vectors++;
    if (wr_pulses != w0 || rd_pulses != r0) begin
      miscompares++;
      $display("FAIL err_mem_access: wr=%0d rd=%0d, expected 0 0", wr_pulses - w0, rd_pulses - r0);
    end
    vectors++;
    if (tb_mem[1] !== pat(1)) begin
      miscompares++;
      $display("FAIL err_mem_unchanged: mem[0x4]=%h, expected %h", tb_mem[1], pat(1));
    end
  endtask

  task automatic test_back_to_back();
    int g0;
    g0 = grant_q.size();
    for (int i = 0; i < 4; i++) req_q0.push_back(mk(1'b0, 32'(i * 4), 32'd0));
    drain(40);
    vectors++;
    if (grant_q.size() != g0 + 4) begin
      miscompares++;
      $display("FAIL b2b_count: grants=%0d, expected 4", grant_q.size() - g0);
    end else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (grant_q[g0 + i].cyc != grant_q[g0 + i - 1].cyc + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: gap=%0d, expected 2", i,
                   grant_q[g0 + i].cyc - grant_q[g0 + i - 1].cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g0, rp0, n;
    g0 = grant_q.size();
    req_q1.push_back(mk(1'b1, 32'h20, 32'h55));
    n = 0;
    while (grant_q.size() == g0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    #2;
    vectors++;
    if (mem_write !== 1'b1 || mem_address !== 32'h20 || mem_write_data !== 32'h55) begin
      miscompares++;
      $display("FAIL mid_access: wr=%b addr=%h data=%h, expected 1 00000020 00000055",
               mem_write, mem_address, mem_write_data);
    end
    rp0 = resp_pulses;
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: wr=%b rd=%b right after reset, expected 0 0", mem_write, mem_read);
    end
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);
    vectors++;
    if (resp_pulses != rp0) begin
      miscompares++;
      $display("FAIL mid_dropped: %0d responses, expected 0", resp_pulses - rp0);
    end
    vectors++;
    if (tb_mem[8] !== pat(8)) begin
      miscompares++;
      $display("FAIL mid_no_commit: mem[0x20]=%h, expected %h", tb_mem[8], pat(8));
    end
    req_q0.push_back(mk(1'b0, 32'h24, 32'd0));
    drain(20);
  endtask

  task automatic test_stats();
    logic [15:0] e0, e1, ee;
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    req_q0.push_back(mk(1'b0, 32'h30, 32'd0));
    req_q0.push_back(mk(1'b0, 32'h34, 32'd0));
    req_q0.push_back(mk(1'b1, 32'h38, 32'hA5A5_0001));
    req_q1.push_back(mk(1'b0, 32'h3C, 32'd0));
    req_q1.push_back(mk(1'b0, 32'h2000, 32'd0));
    drain(60);
`ifdef DMEM_ARB_STATS_EN
    e0 = 16'd3; e1 = 16'd2; ee = 16'd1;
`else
    e0 = 16'd0; e1 = 16'd0; ee = 16'd0;
`endif
    vectors++;
    if (stat_p0_count !== e0) begin
      miscompares++;
      $display("FAIL stat_p0: got %0d, expected %0d", stat_p0_count, e0);
    end
    vectors++;
    if (stat_p1_count !== e1) begin
      miscompares++;
      $display("FAIL stat_p1: got %0d, expected %0d", stat_p1_count, e1);
    end
    vectors++;
    if (stat_err_count !== ee) begin
      miscompares++;
      $display("FAIL stat_err: got %0d, expected %0d", stat_err_count, ee);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_write_read();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
